// File: rtl/sensor_poll_pkg.sv
// Shared definitions for the sensor poll scheduler: FSM state encoding,
// request-byte prefix, reply length and the reply integrity check.
package sensor_poll_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        REQUEST     = 3'd1,
        ANSWER_TIME = 3'd2,
        TIMEOUT     = 3'd3,
        CHECKSUM    = 3'd4,
        SEND_BACK   = 3'd5
    } state_e;

    localparam logic [7:0] REQ_PREFIX = 8'h80;
    localparam int         RESP_BYTES = 3;

    // A reply is good when it echoes the request byte and its last byte is
    // the 8-bit wrap-around sum of the first two.
    function automatic logic replyOk(input logic [7:0] sent,
                                     input logic [7:0] b0,
                                     input logic [7:0] b1,
                                     input logic [7:0] b2);
        logic [7:0] sum;
        sum = b0 + b1;
        return (b0 == sent) && (b2 == sum);
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Round-robin picker: holds the priority pointer and selects the lowest
// requesting index at or above it, wrapping past the last sensor to 0.
module rr_grant #(
    parameter int N_SENSORS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_SENSORS-1:0] req_i,
    input  logic                 advance_i,
    input  logic [3:0]           idx_i,
    output logic [N_SENSORS-1:0] grant_o,
    output logic [3:0]           idx_o,
    output logic                 valid_o
);

    logic [3:0] ptr_q;
    logic [3:0] ptr_d;

    // Move the pointer just past the sensor that was served, wrapping at the end.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            if (idx_i == 4'(N_SENSORS - 1)) begin
                ptr_d = 4'd0;
            end else begin
                ptr_d = idx_i + 4'd1;
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 4'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Scan candidates starting at the pointer; the first requester found wins.
    always_comb begin
        int                   cand;
        logic                 found;
        logic [N_SENSORS-1:0] sel;
        cand    = 0;
        found   = 1'b0;
        sel     = '0;
        grant_o = '0;
        idx_o   = 4'd0;
        for (int i = 0; i < N_SENSORS; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N_SENSORS) begin
                cand = cand - N_SENSORS;
            end
            sel = N_SENSORS'(1) << cand;
            if (!found && (|(req_i & sel))) begin
                found   = 1'b1;
                grant_o = sel;
                idx_o   = 4'(cand);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/sensor_poll_scheduler.sv
// Shares one UART tx/rx pair among up to 16 sensor requesters: grants one
// sensor, sends its request byte, collects and checks the three-byte reply,
// retries on timeout or corruption and strobes one result per transaction.
// Optional feature: define POLL_ALARM_EN to flag results at or above ALARM_LEVEL.
module sensor_poll_scheduler
    import sensor_poll_pkg::*;
#(
    parameter int         N_SENSORS      = 4,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter int         MAX_RETRY      = 2,
    parameter logic [7:0] ALARM_LEVEL    = 8'hC8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_SENSORS-1:0] req_i,
    output logic [N_SENSORS-1:0] grant_o,
    output logic                 tx_dv_o,
    output logic [7:0]           tx_byte_o,
    input  logic                 tx_done_i,
    input  logic                 rx_dv_i,
    input  logic [7:0]           rx_byte_i,
    output logic                 res_valid_o,
    output logic [3:0]           res_sensor_o,
    output logic [7:0]           res_data_o,
    output logic                 res_error_o,
    output logic                 alarm_o,
    output logic                 busy_o
);

    localparam int                   TIMER_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0]   TIMER_LOAD  = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam int                   RETRY_W     = $clog2(MAX_RETRY + 2);
    localparam logic [RETRY_W-1:0]   RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    state_e                 state_q,    state_d;
    logic [N_SENSORS-1:0]   grant_q,    grant_d;
    logic [3:0]             idx_q,      idx_d;
    logic [7:0]             txByte_q,   txByte_d;
    logic                   txDv_q,     txDv_d;
    logic [RETRY_W-1:0]     retry_q,    retry_d;
    logic [1:0]             byteCnt_q,  byteCnt_d;
    logic [TIMER_W-1:0]     timer_q,    timer_d;
    logic [7:0]             rxBytes_q [RESP_BYTES];
    logic [7:0]             rxBytes_d [RESP_BYTES];
    logic                   resValid_q, resValid_d;
    logic [7:0]             resData_q,  resData_d;
    logic                   resError_q, resError_d;
    logic                   alarm_q,    alarm_d;

    logic [N_SENSORS-1:0]   pickGrant;
    logic [3:0]             pickIdx;
    logic                   pickValid;
    logic                   replyPass;
    logic                   alarmHit;

    rr_grant #(
        .N_SENSORS (N_SENSORS)
    ) u_rr_grant (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .advance_i (state_q == SEND_BACK),
        .idx_i     (idx_q),
        .grant_o   (pickGrant),
        .idx_o     (pickIdx),
        .valid_o   (pickValid)
    );

    assign replyPass = replyOk(txByte_q, rxBytes_q[0], rxBytes_q[1], rxBytes_q[2]);

`ifdef POLL_ALARM_EN
    assign alarmHit = (rxBytes_q[1] >= ALARM_LEVEL);
`else
    logic [7:0] unusedAlarmLevel;
    assign unusedAlarmLevel = ALARM_LEVEL;
    assign alarmHit         = 1'b0;
`endif

    // Next-state and registered-output logic for the poll transaction FSM.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        txByte_d   = txByte_q;
        txDv_d     = 1'b0;
        retry_d    = retry_q;
        byteCnt_d  = byteCnt_q;
        timer_d    = timer_q;
        rxBytes_d  = rxBytes_q;
        resValid_d = 1'b0;
        resData_d  = 8'h00;
        resError_d = 1'b0;
        alarm_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pickValid) begin
                    grant_d  = pickGrant;
                    idx_d    = pickIdx;
                    txByte_d = REQ_PREFIX | {4'b0000, pickIdx};
                    txDv_d   = 1'b1;
                    retry_d  = '0;
                    state_d  = REQUEST;
                end
            end

            REQUEST: begin
                if (tx_done_i) begin
                    byteCnt_d = 2'd0;
                    timer_d   = TIMER_LOAD;
                    state_d   = ANSWER_TIME;
                end
            end

            ANSWER_TIME: begin
                if (rx_dv_i) begin
                    rxBytes_d[byteCnt_q] = rx_byte_i;
                    timer_d              = TIMER_LOAD;
                    byteCnt_d            = byteCnt_q + 2'd1;
                    if (byteCnt_q == 2'(RESP_BYTES - 1)) begin
                        state_d = CHECKSUM;
                    end
                end else if (timer_q == '0) begin
                    state_d = TIMEOUT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            CHECKSUM: begin
                if (replyPass) begin
                    resValid_d = 1'b1;
                    resData_d  = rxBytes_q[1];
                    alarm_d    = alarmHit;
                    state_d    = SEND_BACK;
                end else begin
                    state_d = TIMEOUT;
                end
            end

            TIMEOUT: begin
                if (retry_q < RETRY_LIMIT) begin
                    retry_d = retry_q + 1'b1;
                    txDv_d  = 1'b1;
                    state_d = REQUEST;
                end else begin
                    resValid_d = 1'b1;
                    resError_d = 1'b1;
                    state_d    = SEND_BACK;
                end
            end

            SEND_BACK: begin
                grant_d = '0;
                retry_d = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            idx_q      <= 4'd0;
            txByte_q   <= 8'h00;
            txDv_q     <= 1'b0;
            retry_q    <= '0;
            byteCnt_q  <= 2'd0;
            timer_q    <= '0;
            rxBytes_q  <= '{default: 8'h00};
            resValid_q <= 1'b0;
            resData_q  <= 8'h00;
            resError_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            txByte_q   <= txByte_d;
            txDv_q     <= txDv_d;
            retry_q    <= retry_d;
            byteCnt_q  <= byteCnt_d;
            timer_q    <= timer_d;
            rxBytes_q  <= rxBytes_d;
            resValid_q <= resValid_d;
            resData_q  <= resData_d;
            resError_q <= resError_d;
            alarm_q    <= alarm_d;
        end
    end

    assign grant_o      = grant_q;
    assign tx_dv_o      = txDv_q;
    assign tx_byte_o    = txByte_q;
    assign res_valid_o  = resValid_q;
    assign res_sensor_o = idx_q;
    assign res_data_o   = resData_q;
    assign res_error_o  = resError_q;
    assign alarm_o      = alarm_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Directed bench for sensor_poll_scheduler: a table of clean transactions
// plus hand-written sequences for retries, bad checksums and mid-flight reset.
module tb_sensor_poll_scheduler;

    localparam int N   = 4;
    localparam int TMO = 20;

`ifdef POLL_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif

    logic         clk;
    logic         rstN;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         txDv;
    logic [7:0]   txByte;
    logic         txDone;
    logic         rxDv;
    logic [7:0]   rxByte;
    logic         resValid;
    logic [3:0]   resSensor;
    logic [7:0]   resData;
    logic         resError;
    logic         alarm;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int txDvCount = 0;

    typedef struct {
        logic [3:0] req;
        bit         hold;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [3:0] sensor;
        logic [7:0] data;
        bit         alarm;
    } vec_t;

    vec_t vecs [10];

    sensor_poll_scheduler #(
        .N_SENSORS      (N),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRY      (2),
        .ALARM_LEVEL    (8'hC8)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .req_i        (req),
        .grant_o      (grant),
        .tx_dv_o      (txDv),
        .tx_byte_o    (txByte),
        .tx_done_i    (txDone),
        .rx_dv_i      (rxDv),
        .rx_byte_i    (rxByte),
        .res_valid_o  (resValid),
        .res_sensor_o (resSensor),
        .res_data_o   (resData),
        .res_error_o  (resError),
        .alarm_o      (alarm),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (txDv === 1'b1) txDvCount++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic waitTxDv(input int maxCycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (txDv === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitResult(input int maxCycles, output int lat);
        lat = -1;
        for (int i = 1; i <= maxCycles; i++) begin
            @(negedge clk);
            rxDv = 1'b0;
            if (resValid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        rxByte = b;
        rxDv   = 1'b1;
        @(negedge clk);
        rxDv   = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulseTxDone();
        txDone = 1'b1;
        @(negedge clk);
        txDone = 1'b0;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        bit seen;
        int lat;
        req = v.req;
        waitTxDv(40, seen);
        checkOutput("txdv_seen", 32'(seen), 32'd1);
        if (!seen) return;
        if (!v.hold) req = '0;
        checkOutput("tx_byte", 32'(txByte), 32'({4'h8, v.sensor}));
        checkOutput("grant", 32'(grant), 32'(1) << v.sensor);
        checkOutput("busy_req", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("txdv_oneshot", 32'(txDv), 32'd0);
        sendByte(8'h00);
        pulseTxDone();
        sendByte(v.b0);
        sendByte(v.b1);
        rxByte = v.b2;
        rxDv   = 1'b1;
        waitResult(10, lat);
        checkOutput("res_latency", 32'(lat), 32'd2);
        if (lat > 0) begin
            checkOutput("res_sensor", 32'(resSensor), 32'(v.sensor));
            checkOutput("res_data", 32'(resData), 32'(v.data));
            checkOutput("res_error", 32'(resError), 32'd0);
            checkOutput("alarm", 32'(alarm), 32'(v.alarm));
            @(negedge clk);
            checkOutput("res_valid_pulse", 32'(resValid), 32'd0);
            checkOutput("idle_grant", 32'(grant), 32'd0);
            checkOutput("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        bit seen;
        int lat;
        int mark;

        vecs[0] = '{4'hF, 1'b1, 8'h80, 8'h11, 8'h91, 4'd0, 8'h11, 1'b0};
        vecs[1] = '{4'hF, 1'b1, 8'h81, 8'h22, 8'hA3, 4'd1, 8'h22, 1'b0};
        vecs[2] = '{4'hF, 1'b1, 8'h82, 8'h33, 8'hB5, 4'd2, 8'h33, 1'b0};
        vecs[3] = '{4'hF, 1'b1, 8'h83, 8'h44, 8'hC7, 4'd3, 8'h44, 1'b0};
        vecs[4] = '{4'hF, 1'b0, 8'h80, 8'h00, 8'h80, 4'd0, 8'h00, 1'b0};
        vecs[5] = '{4'h4, 1'b0, 8'h82, 8'h37, 8'hB9, 4'd2, 8'h37, 1'b0};
        vecs[6] = '{4'h2, 1'b0, 8'h81, 8'hC8, 8'h49, 4'd1, 8'hC8, ALARM_ON};
        vecs[7] = '{4'h2, 1'b0, 8'h81, 8'hC7, 8'h48, 4'd1, 8'hC7, 1'b0};
        vecs[8] = '{4'h1, 1'b0, 8'h80, 8'hFF, 8'h7F, 4'd0, 8'hFF, ALARM_ON};
        vecs[9] = '{4'h9, 1'b0, 8'h83, 8'h05, 8'h88, 4'd3, 8'h05, 1'b0};

        rstN   = 1'b0;
        req    = '0;
        txDone = 1'b0;
        rxDv   = 1'b0;
        rxByte = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs",
                    32'({grant, txDv, txByte, resValid, resSensor, resData, resError, alarm, busy}),
                    32'd0);
        rstN = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
        end

        // No reply at all: two retries, then an error result for sensor 2.
        mark = txDvCount;
        req  = 4'h4;
        lat  = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            txDone = 1'b0;
            if (txDv === 1'b1) begin
                req    = '0;
                txDone = 1'b1;
                checkOutput("retry_tx_byte", 32'(txByte), 32'h82);
            end
            if (resValid === 1'b1) begin
                lat = i;
                break;
            end
        end
        txDone = 1'b0;
        checkOutput("noreply_result_seen", 32'(lat > 0), 32'd1);
        checkOutput("noreply_txdv_count", 32'(txDvCount - mark), 32'd3);
        checkOutput("noreply_error", 32'(resError), 32'd1);
        checkOutput("noreply_data", 32'(resData), 32'd0);
        checkOutput("noreply_sensor", 32'(resSensor), 32'd2);
        checkOutput("noreply_alarm", 32'(alarm), 32'd0);
        @(negedge clk);

        // Bad checksum first, good reply on the retry; pointer is 3 so sensor 0 wins.
        mark = txDvCount;
        req  = 4'h1;
        waitTxDv(40, seen);
        checkOutput("badsum_first_txdv", 32'(seen), 32'd1);
        req = '0;
        checkOutput("badsum_tx_byte", 32'(txByte), 32'h80);
        @(negedge clk);
        pulseTxDone();
        sendByte(8'h80);
        sendByte(8'h10);
        sendByte(8'h00);
        waitTxDv(20, seen);
        checkOutput("badsum_retry_txdv", 32'(seen), 32'd1);
        @(negedge clk);
        pulseTxDone();
        sendByte(8'h80);
        sendByte(8'h10);
        rxByte = 8'h90;
        rxDv   = 1'b1;
        waitResult(10, lat);
        checkOutput("badsum_latency", 32'(lat), 32'd2);
        checkOutput("badsum_txdv_count", 32'(txDvCount - mark), 32'd2);
        checkOutput("badsum_data", 32'(resData), 32'h10);
        checkOutput("badsum_error", 32'(resError), 32'd0);
        checkOutput("badsum_sensor", 32'(resSensor), 32'd0);
        @(negedge clk);

        // Reset while waiting for the reply; pointer must restart at 0.
        req = 4'h4;
        waitTxDv(40, seen);
        checkOutput("rst_txdv", 32'(seen), 32'd1);
        req = '0;
        checkOutput("rst_tx_byte", 32'(txByte), 32'h82);
        @(negedge clk);
        pulseTxDone();
        sendByte(8'h82);
        checkOutput("rst_busy_before", 32'(busy), 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("rst_outputs",
                    32'({grant, txDv, txByte, resValid, resSensor, resData, resError, alarm, busy}),
                    32'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        applyStimulus('{4'h3, 1'b0, 8'h80, 8'h5A, 8'hDA, 4'd0, 8'h5A, 1'b0});
        applyStimulus('{4'h2, 1'b0, 8'h81, 8'h01, 8'h82, 4'd1, 8'h01, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
